risc_prog_loader: RTL and testbench

//  Parametrised program-loading front end for the risc core. It replaces direct
//  per-pin instruction writes with a byte-stream command port. Bytes are assembled

---
 rtl/risc_prog_loader_if.sv | 34 +++
 rtl/risc_prog_loader.sv | 129 ++++++++++++
 tb/tb_risc_prog_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_prog_loader_if.sv
// Command-byte port and instruction-memory write port of the program loader.
// Handshakes:
//   cmd : a byte/address is transferred on a rising clk edge where
//         cmd_valid & cmd_ready; cmd_valid while cmd_ready=0 is ignored.
//   mem : mem_we is held with stable mem_addr/mem_wdata until the edge where
//         mem_ack=1; mem_ack is ignored while mem_we=0.
interface risc_prog_loader_if #(
  parameter int DATA_W = 8,
  parameter int INST_W = 16,
  parameter int ADDR_W = 7
);
  logic              cmd_valid;
  logic              cmd_is_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              cmd_start;
  logic              cmd_halt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_wdata;
  logic              mem_ack;

  // Loader side.
  modport slave (
    input  cmd_valid, cmd_is_addr, cmd_data, cmd_start, cmd_halt, mem_ack,
    output cmd_ready, mem_we, mem_addr, mem_wdata
  );

  // Host / memory side.
  modport master (
    output cmd_valid, cmd_is_addr, cmd_data, cmd_start, cmd_halt, mem_ack,
    input  cmd_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/risc_prog_loader.sv
// Program-loading front end for the risc core: assembles a byte stream into
// instruction words, writes them to instruction memory at an auto-incrementing
// address, and gates the core reset (run/halt). All outputs are registered.
module risc_prog_loader #(
  parameter int DATA_W = 8,
  parameter int INST_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  risc_prog_loader_if.slave    bus,
  output logic                 cpu_rst_n,
  output logic                 run,
  output logic [DATA_W-1:0]    checksum,
  output logic [ADDR_W:0]      word_count,
  output logic                 wrap,
  output logic [1:0]           dbg_state
);

  localparam int BPW   = INST_W / DATA_W;
  localparam int CNT_W = $clog2(BPW + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    WRITE    = 2'd2,
    RUN      = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] byte_cnt;

  wire take_cmd  = (state == IDLE || state == ASSEMBLE) && !bus.cmd_start && bus.cmd_valid;
  wire take_data = take_cmd && !bus.cmd_is_addr;
  wire take_addr = take_cmd && bus.cmd_is_addr;
  wire take_ack  = (state == WRITE) && bus.mem_ack;

  assign dbg_state = state;

  // The write pointer is presented directly as the memory address.
  // Upper command bits beyond the address width carry no meaning for address commands.
  generate
    if (ADDR_W < DATA_W) begin : g_unused_hi
      logic unused_cmd_hi;
      assign unused_cmd_hi = ^bus.cmd_data[DATA_W-1:ADDR_W];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: start beats any byte in the same cycle, halt beats start in RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ASSEMBLE: begin
        if (bus.cmd_start)            state_next = RUN;
        else if (bus.cmd_valid) begin
          if (bus.cmd_is_addr)        state_next = IDLE;
          else if (byte_cnt == CNT_LAST) state_next = WRITE;
          else                        state_next = ASSEMBLE;
        end
      end
      WRITE:   if (bus.mem_ack)  state_next = IDLE;
      RUN:     if (bus.cmd_halt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cmd_ready <= 1'b1;
      bus.mem_we    <= 1'b0;
      run           <= 1'b0;
      cpu_rst_n     <= 1'b0;
    end else begin
      bus.cmd_ready <= (state_next == IDLE) || (state_next == ASSEMBLE);
      bus.mem_we    <= (state_next == WRITE);
      run           <= (state_next == RUN);
      cpu_rst_n     <= (state_next == RUN);
    end
  end

  // Word assembly, write pointer and load statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      byte_cnt      <= '0;
      checksum      <= '0;
      word_count    <= '0;
      wrap          <= 1'b0;
    end else begin
      if ((state == IDLE || state == ASSEMBLE) && bus.cmd_start) begin
        // Entering RUN drops any partially assembled word.
        byte_cnt <= '0;
      end
      if (take_data) begin
        // MSB-first: earlier bytes are pushed toward the top of the word.
        bus.mem_wdata <= (bus.mem_wdata << DATA_W) | INST_W'(bus.cmd_data);
        checksum      <= checksum ^ bus.cmd_data;
        byte_cnt      <= byte_cnt + CNT_ONE;
      end
      if (take_addr) begin
        bus.mem_addr <= bus.cmd_data[ADDR_W-1:0];
        byte_cnt     <= '0;
        checksum     <= '0;
        word_count   <= '0;
        wrap         <= 1'b0;
      end
      if (take_ack) begin
        bus.mem_addr <= bus.mem_addr + PTR_ONE;
        if (&bus.mem_addr) wrap <= 1'b1;
        if (word_count != '1) word_count <= word_count + WC_ONE;
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed bench for risc_prog_loader: byte assembly, write handshake,
// address commands, wrap, back-pressure, run/halt and asynchronous reset.
module tb_risc_prog_loader;

  localparam int DATA_W = 8;
  localparam int INST_W = 16;
  localparam int ADDR_W = 7;

  logic              clk;
  logic              rst_n;
  logic              cpu_rst_n;
  logic              run;
  logic [DATA_W-1:0] checksum;
  logic [ADDR_W:0]   word_count;
  logic              wrap;
  logic [1:0]        dbg_state;

  int checks;
  int errors;

  risc_prog_loader_if #(.DATA_W(DATA_W), .INST_W(INST_W), .ADDR_W(ADDR_W)) bus ();

  risc_prog_loader #(.DATA_W(DATA_W), .INST_W(INST_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cpu_rst_n  (cpu_rst_n),
    .run        (run),
    .checksum   (checksum),
    .word_count (word_count),
    .wrap       (wrap),
    .dbg_state  (dbg_state)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [DATA_W-1:0] b);
    bus.cmd_valid   = 1'b1;
    bus.cmd_is_addr = 1'b0;
    bus.cmd_data    = b;
    tick();
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic send_addr(input logic [DATA_W-1:0] a);
    bus.cmd_valid   = 1'b1;
    bus.cmd_is_addr = 1'b1;
    bus.cmd_data    = a;
    tick();
    bus.cmd_valid   = 1'b0;
    bus.cmd_is_addr = 1'b0;
  endtask

  // Called just after mem_we rose; acks after 'delay' more cycles and counts
  // the sampled cycles in which mem_we was high.
  task automatic do_ack(input int delay, output int hi);
    hi = 0;
    for (int i = 0; i < delay; i++) begin
      if (bus.mem_we === 1'b1) hi++;
      tick();
    end
    if (bus.mem_we === 1'b1) hi++;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_is_addr = 1'b0; bus.cmd_data = '0;
    bus.cmd_start = 1'b0; bus.cmd_halt = 1'b0; bus.mem_ack = 1'b0;
    #12;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%0h exp=0", bus.mem_we); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%0h exp=1", bus.cmd_ready); end
    checks++; if ({run, cpu_rst_n} !== 2'b00) begin errors++; $display("FAIL reset_run got=%0b exp=00", {run, cpu_rst_n}); end
    checks++; if (bus.mem_addr !== 7'h00) begin errors++; $display("FAIL reset_mem_addr got=%0h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata got=%0h exp=0", bus.mem_wdata); end
    checks++; if ({checksum, word_count, wrap} !== 17'h0) begin errors++; $display("FAIL reset_counters got=%0h exp=0", {checksum, word_count, wrap}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_write();
    int hi;
    send_addr(8'h05);
    checks++; if (bus.mem_addr !== 7'h05) begin errors++; $display("FAIL t1_addr_load got=%0h exp=05", bus.mem_addr); end
    send_byte(8'h12);
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL t1_assemble got=%0d exp=1", dbg_state); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL t1_we_early got=%0h exp=0", bus.mem_we); end
    send_byte(8'h34);
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL t1_we_rise got=%0h exp=1", bus.mem_we); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_write got=%0h exp=0", bus.cmd_ready); end
    checks++; if (bus.mem_addr !== 7'h05) begin errors++; $display("FAIL t1_wr_addr got=%0h exp=05", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 16'h1234) begin errors++; $display("FAIL t1_wr_data got=%0h exp=1234", bus.mem_wdata); end
    tick();
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== {7'h05, 16'h1234}) begin errors++; $display("FAIL t1_stable got=%0h exp=%0h", {bus.mem_addr, bus.mem_wdata}, {7'h05, 16'h1234}); end
    do_ack(1, hi);
    hi++;  // the cycle checked just above
    checks++; if (hi !== 3) begin errors++; $display("FAIL t1_we_cycles got=%0d exp=3", hi); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL t1_we_fall got=%0h exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 7'h06) begin errors++; $display("FAIL t1_next_addr got=%0h exp=06", bus.mem_addr); end
    checks++; if (word_count !== 8'd1) begin errors++; $display("FAIL t1_word_count got=%0d exp=1", word_count); end
    checks++; if (checksum !== 8'h26) begin errors++; $display("FAIL t1_checksum got=%0h exp=26", checksum); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_idle got=%0h exp=1", bus.cmd_ready); end
  endtask

  task automatic test_addr_discard();
    int hi;
    send_byte(8'hAA);
    send_addr(8'h10);
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL t2_idle got=%0d exp=0", dbg_state); end
    checks++; if ({checksum, word_count} !== 16'h0) begin errors++; $display("FAIL t2_clear got=%0h exp=0", {checksum, word_count}); end
    send_byte(8'h01);
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL t2_no_write got=%0h exp=0", bus.mem_we); end
    send_byte(8'h02);
    checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 7'h10, 16'h0102}) begin errors++; $display("FAIL t2_write got=%0h exp=%0h", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 7'h10, 16'h0102}); end
    checks++; if (checksum !== 8'h03) begin errors++; $display("FAIL t2_checksum got=%0h exp=03", checksum); end
    do_ack(0, hi);
    checks++; if (hi !== 1) begin errors++; $display("FAIL t2_we_cycles got=%0d exp=1", hi); end
    checks++; if ({bus.mem_we, word_count, bus.mem_addr} !== {1'b0, 8'd1, 7'h11}) begin errors++; $display("FAIL t2_after got=%0h exp=%0h", {bus.mem_we, word_count, bus.mem_addr}, {1'b0, 8'd1, 7'h11}); end
  endtask

  task automatic test_wrap();
    int hi;
    send_addr(8'h7F);
    send_byte(8'hDE);
    send_byte(8'hAD);
    checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 7'h7F, 16'hDEAD}) begin errors++; $display("FAIL t3_write got=%0h exp=%0h", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 7'h7F, 16'hDEAD}); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL t3_wrap_early got=%0h exp=0", wrap); end
    do_ack(0, hi);
    checks++; if (bus.mem_addr !== 7'h00) begin errors++; $display("FAIL t3_ptr_wrap got=%0h exp=00", bus.mem_addr); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL t3_wrap_set got=%0h exp=1", wrap); end
    send_byte(8'h01);
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL t3_wrap_sticky got=%0h exp=1", wrap); end
    send_addr(8'h00);
    checks++; if ({wrap, word_count, checksum} !== 17'h0) begin errors++; $display("FAIL t3_wrap_clear got=%0h exp=0", {wrap, word_count, checksum}); end
  endtask

  task automatic test_back_pressure();
    int hi;
    send_addr(8'h20);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.cmd_valid   = 1'b1;
    bus.cmd_is_addr = 1'b0;
    bus.cmd_data    = 8'h55;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus.cmd_ready, bus.mem_we, checksum} !== {2'b01, 8'h33}) begin errors++; $display("FAIL t4_hold%0d got=%0h exp=%0h", i, {bus.cmd_ready, bus.mem_we, checksum}, {2'b01, 8'h33}); end
      tick();
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if ({bus.cmd_ready, bus.mem_we, checksum} !== {2'b10, 8'h33}) begin errors++; $display("FAIL t4_after_ack got=%0h exp=%0h", {bus.cmd_ready, bus.mem_we, checksum}, {2'b10, 8'h33}); end
    checks++; if ({word_count, bus.mem_addr} !== {8'd1, 7'h21}) begin errors++; $display("FAIL t4_ptr got=%0h exp=%0h", {word_count, bus.mem_addr}, {8'd1, 7'h21}); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({dbg_state, checksum} !== {2'd1, 8'h66}) begin errors++; $display("FAIL t4_accept_idle got=%0h exp=%0h", {dbg_state, checksum}, {2'd1, 8'h66}); end
  endtask

  task automatic test_run_halt();
    send_addr(8'h40);
    bus.cmd_start   = 1'b1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_is_addr = 1'b0;
    bus.cmd_data    = 8'h77;
    tick();
    bus.cmd_start   = 1'b0;
    checks++; if ({run, cpu_rst_n, bus.cmd_ready} !== 3'b110) begin errors++; $display("FAIL t5_run got=%0b exp=110", {run, cpu_rst_n, bus.cmd_ready}); end
    checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL t5_byte_dropped got=%0h exp=00", checksum); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({dbg_state, checksum} !== {2'd3, 8'h00}) begin errors++; $display("FAIL t5_run_ignore got=%0h exp=%0h", {dbg_state, checksum}, {2'd3, 8'h00}); end
    bus.cmd_halt  = 1'b1;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_halt  = 1'b0;
    bus.cmd_start = 1'b0;
    checks++; if ({run, cpu_rst_n, bus.cmd_ready} !== 3'b001) begin errors++; $display("FAIL t5_halt got=%0b exp=001", {run, cpu_rst_n, bus.cmd_ready}); end
    checks++; if (bus.mem_addr !== 7'h40) begin errors++; $display("FAIL t5_ptr_kept got=%0h exp=40", bus.mem_addr); end
    send_byte(8'h9C);
    send_byte(8'h3E);
    checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 7'h40, 16'h9C3E}) begin errors++; $display("FAIL t5_write_after got=%0h exp=%0h", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 7'h40, 16'h9C3E}); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    int hi;
    // Reset while running.
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL t6_run_before got=%0h exp=1", run); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({run, cpu_rst_n} !== 2'b00) begin errors++; $display("FAIL t6_run_reset got=%0b exp=00", {run, cpu_rst_n}); end
    @(negedge clk);
    rst_n = 1'b1;
    // Reset in the middle of a write.
    send_addr(8'h30);
    send_byte(8'h01);
    send_byte(8'h02);
    do_ack(0, hi);
    send_byte(8'h03);
    send_byte(8'h04);
    checks++; if ({bus.mem_we, word_count, bus.mem_addr} !== {1'b1, 8'd1, 7'h31}) begin errors++; $display("FAIL t6_pre got=%0h exp=%0h", {bus.mem_we, word_count, bus.mem_addr}, {1'b1, 8'd1, 7'h31}); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_we, run, cpu_rst_n} !== 3'b000) begin errors++; $display("FAIL t6_we_reset got=%0b exp=000", {bus.mem_we, run, cpu_rst_n}); end
    checks++; if ({checksum, word_count, wrap, bus.mem_addr} !== 24'h0) begin errors++; $display("FAIL t6_counters got=%0h exp=0", {checksum, word_count, wrap, bus.mem_addr}); end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hCA);
    send_byte(8'hFE);
    checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 7'h00, 16'hCAFE}) begin errors++; $display("FAIL t6_first_write got=%0h exp=%0h", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 7'h00, 16'hCAFE}); end
    do_ack(2, hi);
    checks++; if ({bus.mem_addr, word_count, checksum} !== {7'h01, 8'd1, 8'h34}) begin errors++; $display("FAIL t6_after got=%0h exp=%0h", {bus.mem_addr, word_count, checksum}, {7'h01, 8'd1, 8'h34}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_write();
    test_addr_discard();
    test_wrap();
    test_back_pressure();
    test_run_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
